// File: rtl/calc_disp_pkg.sv
// -----------------------------------------------------------------------------
// calc_disp_pkg
// Shared definitions for the calculator result display path:
//   - conversion FSM state type
//   - BCD scratch width
//   - active-low seven-segment patterns ({g,f,e,d,c,b,a}) for digits,
//     blank and minus
// No ports (package).
// -----------------------------------------------------------------------------
package calc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Three BCD nibbles cover the largest magnitude, 255.
    localparam int BCD_W = 12;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam logic [6:0] SEG_D0 = 7'h40;
    localparam logic [6:0] SEG_D1 = 7'h79;
    localparam logic [6:0] SEG_D2 = 7'h24;
    localparam logic [6:0] SEG_D3 = 7'h30;
    localparam logic [6:0] SEG_D4 = 7'h19;
    localparam logic [6:0] SEG_D5 = 7'h12;
    localparam logic [6:0] SEG_D6 = 7'h02;
    localparam logic [6:0] SEG_D7 = 7'h78;
    localparam logic [6:0] SEG_D8 = 7'h00;
    localparam logic [6:0] SEG_D9 = 7'h10;

endpackage

// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Combinational BCD digit to active-low seven-segment pattern.
// Ports:
//   digit  in   4  BCD digit (0..9); codes above 9 render blank
//   blank  in   1  force the blank pattern
//   seg    out  7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_D0;
                4'd1:    seg = SEG_D1;
                4'd2:    seg = SEG_D2;
                4'd3:    seg = SEG_D3;
                4'd4:    seg = SEG_D4;
                4'd5:    seg = SEG_D5;
                4'd6:    seg = SEG_D6;
                4'd7:    seg = SEG_D7;
                4'd8:    seg = SEG_D8;
                4'd9:    seg = SEG_D9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display_scan.sv
// -----------------------------------------------------------------------------
// result_display_scan
// Converts the stored 8-bit calculator result to BCD with a sequential
// shift-add-3 engine and scans it onto a 4-digit common-anode display.
// Digit 3 carries an optional minus sign; leading zeros are blanked.
// Ports:
//   in_CLK     in   1  system clock
//   in_RST     in   1  synchronous active-high reset
//   in_VALUE   in   8  result word
//   in_LOAD    in   1  capture in_VALUE and start conversion (ignored when busy)
//   in_SIGNED  in   1  treat in_VALUE as two's complement (sampled with load)
//   out_SEG    out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//   out_AN     out  4  anodes, active-low one-hot, bit 0 = ones, registered
//   out_BUSY   out  1  conversion in progress
//   out_DONE   out  1  one-cycle pulse as new digits are committed
// -----------------------------------------------------------------------------
module result_display_scan
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       in_CLK,
    input  logic       in_RST,
    input  logic [7:0] in_VALUE,
    input  logic       in_LOAD,
    input  logic       in_SIGNED,
    output logic [6:0] out_SEG,
    output logic [3:0] out_AN,
    output logic       out_BUSY,
    output logic       out_DONE
);

    state_t           state;
    logic [2:0]       iter;
    logic [7:0]       mag;
    logic             sign_cap;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] scratch_adj;

    logic [BCD_W-1:0] disp_bcd;
    logic             disp_neg;
    logic             disp_valid;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;

    logic             commit;
    logic [BCD_W-1:0] view_bcd;
    logic             view_neg;
    logic             view_valid;
    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_next;

    assign commit   = (state == ST_COMMIT);
    assign out_BUSY = (state != ST_IDLE);
    assign out_DONE = commit;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Control: conversion FSM and committed digit registers.
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            state      <= ST_IDLE;
            iter       <= '0;
            disp_bcd   <= '0;
            disp_neg   <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_LOAD) begin
                        state <= ST_SHIFT;
                        iter  <= '0;
                    end
                end
                ST_SHIFT: begin
                    iter <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp_bcd   <= scratch;
                    disp_neg   <= sign_cap;
                    disp_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: magnitude/sign capture and the double-dabble shift register.
    // Negation in 8 bits is exact for 0x80 (gives 128 unsigned).
    always_ff @(posedge in_CLK) begin
        if (state == ST_IDLE && in_LOAD) begin
            if (in_SIGNED && in_VALUE[7]) begin
                mag      <= ~in_VALUE + 8'd1;
                sign_cap <= 1'b1;
            end else begin
                mag      <= in_VALUE;
                sign_cap <= 1'b0;
            end
            scratch <= '0;
        end else if (state == ST_SHIFT) begin
            {scratch, mag} <= {scratch_adj, mag} << 1;
        end
    end

    // During the commit cycle the output register reads the freshly converted
    // digits directly, so the new value appears on the same edge that commits it.
    assign view_bcd   = commit ? scratch  : disp_bcd;
    assign view_neg   = commit ? sign_cap : disp_neg;
    assign view_valid = commit | disp_valid;

    always_comb begin
        dec_digit = view_bcd[3:0];
        dec_blank = 1'b0;
        case (digit_idx)
            2'd0: begin
                dec_digit = view_bcd[3:0];
                dec_blank = 1'b0;
            end
            2'd1: begin
                dec_digit = view_bcd[7:4];
                dec_blank = (view_bcd[11:4] == 8'd0);
            end
            2'd2: begin
                dec_digit = view_bcd[11:8];
                dec_blank = (view_bcd[11:8] == 4'd0);
            end
            default: begin
                dec_digit = 4'd0;
                dec_blank = 1'b1;
            end
        endcase
    end

    seg_decode u_seg_decode (
        .digit (dec_digit),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    assign seg_next = (digit_idx == 2'd3) ? (view_neg ? SEG_MINUS : SEG_BLANK)
                                          : dec_seg;

    // Scan: free-running refresh counter, digit index and registered outputs.
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            out_AN      <= 4'b1111;
            out_SEG     <= SEG_BLANK;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end

            if (view_valid) begin
                out_AN  <= ~(4'b0001 << digit_idx);
                out_SEG <= seg_next;
            end else begin
                out_AN  <= 4'b1111;
                out_SEG <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_result_display_scan.sv
// -----------------------------------------------------------------------------
// tb_result_display_scan
// Self-checking bench for result_display_scan with REFRESH_DIV=4. A decimal
// reference model (value, sign, busy countdown, scan position) predicts every
// output after every clock edge. Directed scenarios come first, then random
// loads, signedness and occasional resets.
// -----------------------------------------------------------------------------
module tb_result_display_scan;

    localparam int DIV = 4;

    logic       in_CLK = 1'b0;
    logic       in_RST = 1'b1;
    logic [7:0] in_VALUE = 8'h00;
    logic       in_LOAD = 1'b0;
    logic       in_SIGNED = 1'b0;
    logic [6:0] out_SEG;
    logic [3:0] out_AN;
    logic       out_BUSY;
    logic       out_DONE;

    result_display_scan #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .in_CLK    (in_CLK),
        .in_RST    (in_RST),
        .in_VALUE  (in_VALUE),
        .in_LOAD   (in_LOAD),
        .in_SIGNED (in_SIGNED),
        .out_SEG   (out_SEG),
        .out_AN    (out_AN),
        .out_BUSY  (out_BUSY),
        .out_DONE  (out_DONE)
    );

    always #5 in_CLK = ~in_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_k     = 0;   // edges since reset
    bit m_valid = 0;   // something has been committed
    int m_rem   = 0;   // edges left until the pending value is shown
    int m_mag   = 0;   // shown magnitude
    bit m_neg   = 0;   // shown sign
    int p_mag   = 0;   // pending magnitude
    bit p_neg   = 0;   // pending sign

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int idx);
        int h, t, o;
        h = m_mag / 100;
        t = (m_mag / 10) % 10;
        o = m_mag % 10;
        case (idx)
            0:       return seg_tab[o];
            1:       return (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
            2:       return (h == 0) ? 7'h7F : seg_tab[h];
            default: return m_neg ? 7'h3F : 7'h7F;
        endcase
    endfunction

    task automatic tick(input bit rst, input bit load, input bit sgn, input logic [7:0] val);
        int         idx;
        logic [3:0] an_exp;
        in_RST    = rst;
        in_LOAD   = load;
        in_SIGNED = sgn;
        in_VALUE  = val;
        @(posedge in_CLK);
        if (rst) begin
            m_k = 0; m_valid = 0; m_rem = 0; m_mag = 0; m_neg = 0;
        end else begin
            m_k++;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_valid = 1;
                    m_mag   = p_mag;
                    m_neg   = p_neg;
                end
            end else if (load) begin
                m_rem = 9;
                if (sgn && int'(val) >= 128) begin
                    p_mag = 256 - int'(val);
                    p_neg = 1;
                end else begin
                    p_mag = int'(val);
                    p_neg = 0;
                end
            end
        end
        #1;
        check("busy", out_BUSY, m_rem > 0);
        check("done", out_DONE, m_rem == 1);
        if (!m_valid) begin
            check("an_blank", out_AN, 4'hF);
            check("seg_blank", out_SEG, 7'h7F);
        end else begin
            idx    = ((m_k - 1) / DIV) % 4;
            an_exp = ~(4'b0001 << idx);
            check("an", out_AN, an_exp);
            check("seg", out_SEG, exp_seg(idx));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 8'h00);
    endtask

    task automatic load(input bit sgn, input logic [7:0] val);
        tick(0, 1, sgn, val);
    endtask

    initial begin
        tick(1, 0, 0, 8'h00);
        tick(1, 0, 0, 8'h00);
        idle(20);

        load(0, 8'hFF);  idle(30);
        load(1, 8'h80);  idle(30);
        load(1, 8'hFF);  idle(30);

        load(0, 8'h07);  idle(12);
        load(0, 8'h2A);  idle(2);
        load(0, 8'h63);  idle(30);

        load(0, 8'h05);  idle(12);
        load(0, 8'hC8);  idle(3);
        tick(1, 0, 0, 8'h00);
        idle(3);
        load(0, 8'h00);  idle(30);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                tick(1, 0, 0, 8'h00);
            else
                tick(0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
